// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply (radix-2 Booth) and divide
// (restoring on magnitudes) sequencer that owns the HI/LO result registers.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   start        operation request, sampled only in IDLE
//   op           0 = signed multiply, 1 = signed divide (sampled with start)
//   a, b         operands (signed), latched on the accepting edge
//   busy         high while iterating (MULT or DIV)
//   done         one-cycle completion pulse
//   hi, lo       mult: {hi,lo} = product; div: hi = remainder, lo = quotient
//   div_by_zero  set by a divide with b == 0, cleared by the next accepted start
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]    cnt;
    logic             last;
    // mult: {upper, multiplier, q(-1)}; div: {0, remainder, dividend/quotient}
    logic [2*WIDTH:0] acc;
    logic [WIDTH-1:0] opnd;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   bsum;
    logic [2*WIDTH:0] mult_nx;
    logic [WIDTH:0]   dshift;
    logic [WIDTH:0]   dtrial;
    logic [2*WIDTH:0] div_nx;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign last  = (cnt == CW'(WIDTH - 1));
    assign busy  = (state == MULT) || (state == DIV);
    assign done  = (state == DONE);
    assign mag_a = a[WIDTH-1] ? -a : a;
    assign mag_b = b[WIDTH-1] ? -b : b;

    always_comb begin
        // Upper half summed in WIDTH+1 bits so that adding -(-2^(W-1))
        // keeps its true sign before the arithmetic shift.
        bsum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        case (acc[1:0])
            2'b01:   bsum = bsum + {opnd[WIDTH-1], opnd};
            2'b10:   bsum = bsum - {opnd[WIDTH-1], opnd};
            default: bsum = bsum;
        endcase
        mult_nx = {bsum[WIDTH:1], bsum[0], acc[WIDTH:2], acc[1]};
    end

    always_comb begin
        dshift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        dtrial = dshift - {1'b0, opnd};
        if (dtrial[WIDTH]) begin
            div_nx = {1'b0, dshift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            div_nx = {1'b0, dtrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
        q_fix = neg_q ? -div_nx[WIDTH-1:0] : div_nx[WIDTH-1:0];
        r_fix = neg_r ? -div_nx[2*WIDTH-1:WIDTH]
                      : div_nx[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!op) begin
                        state_nx = MULT;
                    end else if (b != '0) begin
                        state_nx = DIV;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            MULT:    if (last) state_nx = DONE;
            DIV:     if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt         <= '0;
                        div_by_zero <= op && (b == '0);
                        if (!op) begin
                            opnd <= a;
                            acc  <= {{WIDTH{1'b0}}, b, 1'b0};
                        end else if (b != '0) begin
                            opnd  <= mag_b;
                            acc   <= {{(WIDTH+1){1'b0}}, mag_a};
                            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                            neg_r <= a[WIDTH-1];
                        end else begin
                            hi <= a;
                            lo <= '1;
                        end
                    end
                end
                MULT: begin
                    acc <= mult_nx;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        {hi, lo} <= mult_nx[2*WIDTH:1];
                    end
                end
                DIV: begin
                    acc <= div_nx;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative signed multiply/divide sequencer for the multicycle CPU; implements mult/div and owns the HI/LO result registers.
- The control unit pulses start with the operands from the A/B registers, then waits in a stall state while busy=1.
- On completion it gets a one-cycle done pulse; mfhi/mflo read hi/lo through the MemToReg mux.

Parameters:
WIDTH, 32, operand width in bits; also the number of compute iterations.

Ports:
clock  input  1  system clock, rising-edge.
reset  input  1  one clock; reset is asynchronous and active-low.
start  input  1  request pulse; sampled only in IDLE.
op  input  1  0 = signed multiply, 1 = signed divide; sampled with start.
a  input  WIDTH  multiplicand / dividend (signed); sampled with start.
b  input  WIDTH  multiplier / divisor (signed); sampled with start.
busy  output  1  high while computing (MULT or DIV state).
done  output  1  one-cycle completion pulse (DONE state).
hi  output  WIDTH  mult: upper product half; div: remainder.
lo  output  WIDTH  mult: lower product half; div: quotient.
div_by_zero  output  1  set when a divide with b==0 completes; cleared on next accepted start.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0, iteration counter=0. Reset mid-operation aborts the operation with no partial hi/lo update.
- States: IDLE, MULT, DIV, DONE.
- IDLE:
  - start=1, op=0 -> MULT.
  - start=1, op=1, b!=0 -> DIV.
  - start=1, op=1, b==0 -> DONE directly.
  - Operands are latched on the accepting edge.
- MULT: radix-2 Booth on a 2*WIDTH+1 accumulator; one iteration per cycle; counter runs 0..WIDTH-1. Exit to DONE after WIDTH cycles.
- DIV:
  - Restoring division on magnitudes |a| and |b|; one quotient bit per cycle; WIDTH cycles, then DONE.
  - Sign fixup happens on the DONE transition. Quotient is negated if the sign of a differs from the sign of b (truncation toward zero). Remainder takes the sign of a.
  - Magnitudes are WIDTH-bit unsigned, so |-2^(WIDTH-1)| is representable.
- DONE: lasts exactly one cycle; done=1, busy=0; hi/lo are updated on the edge entering DONE; next state IDLE.
- Latency: start accepted at edge E0; busy=1 for cycles E0+1..E0+WIDTH; done=1 in cycle E0+WIDTH+1. For div-by-zero, done=1 in cycle E0+1 and busy is never asserted.
- Result registers:
  - hi/lo hold their value from DONE until the next completion. They are not cleared on start, so mfhi during a stall returns old values.
  - Multiply: {hi,lo} = full 2*WIDTH signed product.
  - Divide by zero: hi=a, lo=all ones, div_by_zero=1.
  - Overflow case -2^(WIDTH-1) / -1: lo=0x80000000, hi=0; no flag.
- start during MULT, DIV or DONE: ignored; op/a/b changes in those states are ignored (operands are latched).
- start held high across DONE->IDLE: a new operation is accepted in the IDLE cycle. Back-to-back period is WIDTH+2 cycles.
- div_by_zero clears on the edge that accepts any new start.

Test Plan:
- Multiply: op=0, a=7, b=-3 (0xFFFFFFFD) -> busy for cycles 1..32; done in cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Multiply extremes: a=b=0x80000000 -> hi=0x40000000, lo=0x00000000. Also a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0, lo=1.
- Signed divide: a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also a=7, b=-2 -> lo=0xFFFFFFFD, hi=1. Also a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- Divide by zero: a=0x1234, b=0 -> done in cycle 1, busy never high; hi=0x1234, lo=0xFFFFFFFF, div_by_zero=1. A following mult start clears div_by_zero on its accepting edge.
- Busy protection: start a=5, b=6 mult, then pulse start with op=1, a=100, b=3 at cycle 10 -> ignored; result hi=0, lo=30; exactly one done pulse.
- Reset mid-operation: prior result hi=0, lo=30; start a=9, b=9 mult; drive reset=0 at cycle 15 asynchronously -> busy, done and the flag drop immediately; hi=lo=0; after release, IDLE accepts a new start normally.
